// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the 32-bit MIPS core.
//   - CTRL_W and bit positions of the decoded control bundle
//   - instruction field positions (R/I format)
package mips_pkg;

    localparam int CTRL_W = 9;

    // Control bundle bit map: {reg_write, mem_read, mem_write, mem_to_reg,
    //                          alu_src, reg_dst, alu_op[2:0]}
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_OP_MSB = 2;
    localparam int CTRL_ALU_OP_LSB = 0;

    // Instruction field positions
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
// Ports:
//   i_ex_valid, i_ex_mem_read, i_ex_rt : instruction currently in EX
//   i_id_valid, i_id_rs, i_id_rt       : instruction currently in ID
//   i_ex_flush                         : taken branch in EX kills ID, so no stall
//   o_stall                            : hold PC and IF/ID, bubble EX
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_ex_flush,
    output logic       o_stall
);

    // $0 is never a hazard source.
    logic w_rt_match;
    assign w_rt_match = (i_ex_rt != 5'd0) &&
                        ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

    assign o_stall = i_id_valid & i_ex_valid & i_ex_mem_read & w_rt_match & ~i_ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MIPS core.
//   Captures operands, control bundle and instruction fields; inserts a
//   bubble on load-use hazards; kills the ID instruction on ex_flush;
//   counts bubble cycles in a saturating counter.
// Parameters: CTRL_W (control bundle width), CNT_W (stall counter width).
// Ports:
//   clk, rst (async, active-low)
//   id_valid, id_instr, id_pc_plus4, id_ctrl, rd_data1, rd_data2 : ID inputs
//   wb_reg_write, wb_write_reg, wb_write_data                     : WB write port
//   ex_flush                                                      : taken branch in EX
//   stall                                                         : combinational hold
//   ex_*                                                          : registered EX bundle
//   stall_count                                                   : bubble cycles since reset
// Build option: ID_EX_WB_BYPASS_EN forwards the WB write data into the
//   operands when WB targets rs/rt in the same cycle.
module id_ex_stage #(
    parameter int CTRL_W = mips_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc_plus4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       rd_data1,
    input  logic [31:0]       rd_data2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [31:0]       wb_write_data,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [5:0]        ex_funct,
    output logic [31:0]       ex_pc_plus4,
    output logic [CNT_W-1:0]  stall_count
);

    import mips_pkg::*;

    logic [4:0]        w_rs, w_rt;
    logic [31:0]       w_a_src, w_b_src, w_a, w_b, w_imm;
    logic              w_stall;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_a, r_b, r_imm, r_pc_plus4;
    logic [4:0]        r_rs, r_rt, r_rd, r_shamt;
    logic [5:0]        r_funct;
    logic [CNT_W-1:0]  r_cnt;

    assign w_rs  = id_instr[RS_MSB:RS_LSB];
    assign w_rt  = id_instr[RT_MSB:RT_LSB];
    assign w_imm = {{16{id_instr[IMM_MSB]}}, id_instr[IMM_MSB:IMM_LSB]};

`ifdef ID_EX_WB_BYPASS_EN
    assign w_a_src = (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == w_rs))
                     ? wb_write_data : rd_data1;
    assign w_b_src = (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == w_rt))
                     ? wb_write_data : rd_data2;
`else
    // Register file is write-before-read; WB port is not needed here.
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_reg_write, wb_write_reg, wb_write_data};
    assign w_a_src = rd_data1;
    assign w_b_src = rd_data2;
`endif

    // $0 reads as zero whatever the register file or bypass says.
    assign w_a = (w_rs == 5'd0) ? 32'd0 : w_a_src;
    assign w_b = (w_rt == 5'd0) ? 32'd0 : w_b_src;

    load_use_detect u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
        .i_ex_rt       (r_rt),
        .i_id_valid    (id_valid),
        .i_id_rs       (w_rs),
        .i_id_rt       (w_rt),
        .i_ex_flush    (ex_flush),
        .o_stall       (w_stall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_pc_plus4 <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_shamt    <= '0;
            r_funct    <= '0;
            r_cnt      <= '0;
        end else begin
            // Data fields load every cycle; only valid/ctrl decide whether
            // EX acts on them.
            r_a        <= w_a;
            r_b        <= w_b;
            r_imm      <= w_imm;
            r_pc_plus4 <= id_pc_plus4;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
            r_rd       <= id_instr[RD_MSB:RD_LSB];
            r_shamt    <= id_instr[SHAMT_MSB:SHAMT_LSB];
            r_funct    <= id_instr[FUNCT_MSB:FUNCT_LSB];
            if (ex_flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (w_stall) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                if (r_cnt != '1)
                    r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_valid <= id_valid;
                r_ctrl  <= id_valid ? id_ctrl : '0;
            end
        end
    end

    assign stall       = w_stall;
    assign ex_valid    = r_valid;
    assign ex_ctrl     = r_ctrl;
    assign ex_a        = r_a;
    assign ex_b        = r_b;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_shamt    = r_shamt;
    assign ex_funct    = r_funct;
    assign ex_pc_plus4 = r_pc_plus4;
    assign stall_count = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int CW = 8;  // narrow counter so saturation is reachable quickly

`ifdef ID_EX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [8:0] C_LW  = 9'b110110000;
    localparam logic [8:0] C_ADD = 9'b100001010;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus4, rd_data1, rd_data2, wb_write_data;
    logic [8:0]  id_ctrl;
    logic        wb_reg_write, ex_flush;
    logic [4:0]  wb_write_reg;
    logic        stall, ex_valid;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc_plus4;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]  ex_funct;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(9), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .id_ctrl(id_ctrl), .rd_data1(rd_data1),
        .rd_data2(rd_data2), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .ex_flush(ex_flush), .stall(stall),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4),
        .stall_count(stall_count)
    );

    typedef struct {
        logic          valid;
        logic [8:0]    ctrl;
        logic [31:0]   a, b, imm, pc;
        logic [4:0]    rs, rt, rd, shamt;
        logic [5:0]    funct;
        logic [CW-1:0] cnt;
    } ex_t;

    ex_t m;          // expected EX contents after the next edge
    ex_t q[$];       // scoreboard
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ex_t zero_ex();
        ex_t z;
        z.valid = 0; z.ctrl = 0; z.a = 0; z.b = 0; z.imm = 0; z.pc = 0;
        z.rs = 0; z.rt = 0; z.rd = 0; z.shamt = 0; z.funct = 0; z.cnt = 0;
        return z;
    endfunction

    // One ID cycle: apply inputs, check stall, predict the post-edge EX state.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [8:0] c,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                         input logic fl);
        logic [4:0] rs, rt;
        logic       es;
        ex_t        nx;
        @(negedge clk);
        id_valid = v; id_instr = ins; id_ctrl = c; rd_data1 = d1; rd_data2 = d2;
        wb_reg_write = wbw; wb_write_reg = wbr; wb_write_data = wbd; ex_flush = fl;
        id_pc_plus4 = $urandom;
        #1;
        rs = ins[25:21];
        rt = ins[20:16];
        es = v && m.valid && m.ctrl[7] && (m.rt != 0) && (m.rt == rs || m.rt == rt) && !fl;
        chk("stall", {31'd0, stall}, {31'd0, es});
        nx       = m;
        nx.rs    = rs;
        nx.rt    = rt;
        nx.rd    = ins[15:11];
        nx.shamt = ins[10:6];
        nx.funct = ins[5:0];
        nx.imm   = {{16{ins[15]}}, ins[15:0]};
        nx.pc    = id_pc_plus4;
        nx.a     = (rs == 0) ? 32'd0 : ((BYP && wbw && wbr != 0 && wbr == rs) ? wbd : d1);
        nx.b     = (rt == 0) ? 32'd0 : ((BYP && wbw && wbr != 0 && wbr == rt) ? wbd : d2);
        if (fl) begin
            nx.valid = 0; nx.ctrl = 0;
        end else if (es) begin
            nx.valid = 0; nx.ctrl = 0;
            if (m.cnt != {CW{1'b1}}) nx.cnt = m.cnt + 1'b1;
        end else begin
            nx.valid = v; nx.ctrl = v ? c : 9'd0;
        end
        m = nx;
        q.push_back(nx);
    endtask

    task automatic op(input logic [31:0] ins, input logic [8:0] c,
                      input logic [31:0] d1, input logic [31:0] d2);
        drive(1'b1, ins, c, d1, d2, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_ctrl"}, {23'd0, ex_ctrl}, 32'd0);
        chk({tag, "_data"}, ex_a | ex_b | ex_imm | ex_pc_plus4, 32'd0);
        chk({tag, "_fields"}, {6'd0, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct}, 32'd0);
        chk({tag, "_count"}, {24'd0, stall_count}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        q.delete();
        m = zero_ex();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: the DUT presents a new EX bundle after every edge.
    initial begin
        ex_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
                chk("ex_ctrl", {23'd0, ex_ctrl}, {23'd0, e.ctrl});
                chk("stall_count", {24'd0, stall_count}, {24'd0, e.cnt});
                if (e.valid) begin
                    chk("ex_a", ex_a, e.a);
                    chk("ex_b", ex_b, e.b);
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_pc_plus4", ex_pc_plus4, e.pc);
                    chk("ex_fields", {6'd0, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct},
                        {6'd0, e.rs, e.rt, e.rd, e.shamt, e.funct});
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] LW8  = {6'h23, 5'd9, 5'd8, 16'd0};
    localparam logic [31:0] ADD  = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] LW0  = {6'h23, 5'd9, 5'd0, 16'd0};
    localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd11, 5'd10, 5'd0, 6'h20};

    initial begin
        logic [31:0] ins;
        logic [8:0]  c;
        logic [CW-1:0] cnt_before;
        m = zero_ex();
        id_valid = 0; id_instr = 0; id_pc_plus4 = 0; id_ctrl = 0;
        rd_data1 = 0; rd_data2 = 0; wb_reg_write = 0; wb_write_reg = 0;
        wb_write_data = 0; ex_flush = 0;
        #2;
        do_reset();

        // Load-use: exactly one bubble, then add enters EX
        op(LW8, C_LW, 32'h1111, 32'h2222);
        op(ADD, C_ADD, 32'h3333, 32'h4444);
        after_edge();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {23'd0, ex_ctrl}, 32'd0);
        chk("lu_count", {24'd0, stall_count}, 32'd1);
        op(ADD, C_ADD, 32'h3333, 32'h4444);
        after_edge();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd10);
        chk("lu_count_hold", {24'd0, stall_count}, 32'd1);

        // Register 0: no hazard, operand forced to zero
        op(LW0, C_LW, 32'h0, 32'h0);
        op(ADD0, C_ADD, 32'hDEADBEEF, 32'h5);
        after_edge();
        chk("r0_valid", {31'd0, ex_valid}, 32'd1);
        chk("r0_ex_a", ex_a, 32'd0);

        // Flush over a load-use condition
        op(LW8, C_LW, 32'h1, 32'h2);
        cnt_before = m.cnt;
        drive(1'b1, ADD, C_ADD, 32'h3, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1);
        after_edge();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_count", {24'd0, stall_count}, {24'd0, cnt_before});

        // Immediate sign extension
        op({6'h08, 5'd1, 5'd2, 16'h8004}, C_ADD, 32'h0, 32'h0);
        after_edge();
        chk("imm_neg", ex_imm, 32'hFFFF8004);
        op({6'h08, 5'd1, 5'd2, 16'h7FFF}, C_ADD, 32'h0, 32'h0);
        after_edge();
        chk("imm_pos", ex_imm, 32'h00007FFF);

        // WB bypass into rs
        drive(1'b1, {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}, C_ADD, 32'h0, 32'h9,
              1'b1, 5'd5, 32'h12345678, 1'b0);
        after_edge();
        chk("bypass_ex_a", ex_a, BYP ? 32'h12345678 : 32'h0);

        // Randomized traffic, small register range to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            c = 9'($urandom);
            drive(($urandom_range(0, 9) != 0), ins, c,
                  ($urandom_range(0, 3) == 0) ? 32'hDEADBEEF : $urandom, $urandom,
                  1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a stall
        op(LW8, C_LW, 32'h1, 32'h2);
        drive(1'b1, ADD, C_ADD, 32'h3, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        #2;
        do_reset();

        // Saturation: 2^CW + 3 bubbles
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            op(LW8, C_LW, 32'h1, 32'h2);
            op(ADD, C_ADD, 32'h3, 32'h4);
        end
        after_edge();
        chk("sat_count", {24'd0, stall_count}, {24'd0, {CW{1'b1}}});

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the 32-bit MIPS core. Sits directly downstream of the register file. It captures the two register read values, the decoded control bundle and the instruction fields into the ID/EX pipeline register. It also detects load-use hazards, inserts bubbles, honours branch flushes and keeps a saturating stall counter.

## Interface
Parameters:
- `CTRL_W`, 9: width of the decoded control bundle; bit map lives in the shared package.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  single core clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_instr`  in  32  instruction in ID.
- `id_pc_plus4`  in  32  PC+4 of that instruction.
- `id_ctrl`  in  CTRL_W  decoded control bundle: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0].
- `rd_data1`, `rd_data2`  in  32  register-file read data for rs/rt.
- `wb_reg_write`  in  1  WB stage is writing the register file.
- `wb_write_reg`  in  5  WB destination register.
- `wb_write_data`  in  32  WB data.
- `ex_flush`  in  1  branch/jump resolved taken in EX; kill the instruction in ID.
- `stall`  out  1  combinational; hold PC and IF/ID.
- `ex_valid`  out  1  EX slot holds a real instruction.
- `ex_ctrl`  out  CTRL_W  registered control bundle.
- `ex_a`, `ex_b`  out  32  registered operands.
- `ex_imm`  out  32  sign-extended `instr[15:0]`.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  register fields.
- `ex_shamt`  out  5  shift amount field.
- `ex_funct`  out  6  function field.
- `ex_pc_plus4`  out  32  registered PC+4.
- `stall_count`  out  CNT_W  number of bubble cycles since reset.

## Operation
- Hazard rule: `stall = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & ~ex_flush`.
- Per-edge priority is flush, then stall, then normal.
- **Flush**:
  - `ex_valid <= 0` and `ex_ctrl <= 0`.
  - Data fields are don't-care; they are loaded as in normal operation.
- **Stall**:
  - Bubble: `ex_valid <= 0` and `ex_ctrl <= 0`.
  - The ID instruction is retained upstream and re-presented next cycle.
  - `stall_count` increments, saturating at all-ones.
- **Normal**:
  - `ex_valid <= id_valid`.
  - `ex_ctrl <= id_valid ? id_ctrl : 0`.
  - All fields load from ID.
- Operands: `ex_a` comes from rs and `ex_b` from rt. Each is forced to 0 when its field is 0, independent of `rd_data`.
- Immediate: `ex_imm = {{16{instr[15]}}, instr[15:0]}`.
- `stall_count` counts only cycles where `stall` is 1 at the edge. Flush cycles are not counted.
- Flush coinciding with a would-be stall: no stall, no count; the ID instruction dies.
- Register 0 is never a hazard source and never a bypass source.

## Timing
- One-cycle latency: ID inputs sampled at edge N appear on `ex_*` after edge N.
- `stall` is combinational from the current `ex_*` state, `id_instr` and `ex_flush`. It has no register.
- A load-use pair produces exactly one bubble. On the next cycle `ex_mem_read` is 0, so `stall` drops.
- Reset (asynchronous, active-low) forces all outputs to 0, including `ex_valid`, `ex_ctrl` and `stall_count`. `stall` then evaluates to 0.
- Reset mid-stall discards the pending bubble and any held state.
- Reset is released synchronously by the system.

## Configuration
- Macro `ID_EX_WB_BYPASS_EN`.
- **Defined**: if `wb_reg_write & (wb_write_reg != 0) & (wb_write_reg == id_rs)`, then `ex_a` loads `wb_write_data` instead of `rd_data1`. The same applies to rt and `ex_b`. Bypass is applied before the register-0 forcing rule.
- **Undefined**: operands come from `rd_data1`/`rd_data2` only. The core relies on register-file write-before-read.

## Structure
- Shared package `mips_pkg`:
  - `CTRL_W` and the control-bundle bit-index constants (`CTRL_REG_WRITE` … `CTRL_ALU_OP_LSB`).
  - Instruction field position constants.
- One natural sub-module: `load_use_detect`, the combinational stall equation. Its inputs are the EX rt/mem_read/valid, the ID rs/rt/valid and `ex_flush`.
- The pipeline register and counter stay in `id_ex_stage`.

## Test plan
- **Reset**: assert `rst`=0 mid-run. All `ex_*`, `stall` and `stall_count` read 0 immediately, with no clock edge.
- **Load-use**:
  - Stimulus: `lw $8,0($9)` then `add $10,$8,$11`.
  - `stall` is 1 for one cycle, then `ex_valid` is 0 with `ex_ctrl` = 0.
  - Next edge, `add` enters EX and `stall_count` = 1.
- **Register 0**: `lw $0` then `add $10,$0,$11` gives no stall, and `ex_a` = 0 even with `rd_data1` = `32'hDEADBEEF`.
- **Flush**: `ex_flush` = 1 while a load-use condition holds. `stall` = 0, `ex_valid` = 0 next cycle, `stall_count` unchanged.
- **Immediate**: `instr[15:0]` = `16'h8004` gives `ex_imm` = `32'hFFFF8004`; `16'h7FFF` gives `32'h00007FFF`.
- **Bypass**:
  - Stimulus: `wb_reg_write` = 1, `wb_write_reg` = 5, `wb_write_data` = `32'h12345678`, `id_rs` = 5, `rd_data1` = `32'h0`.
  - `ex_a` = `32'h12345678` with `ID_EX_WB_BYPASS_EN` defined, 0 without it.
- **Saturation**: force 2^CNT_W + 3 stalls; `stall_count` holds at all-ones.
